uart_core_param: RTL and testbench



---
 rtl/uart_core_param.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_core_param
// Purpose  : Parametrised UART transceiver. The TX side uses a valid/ready
//            handshake. The RX side uses mid-bit sampling, rejects false
//            starts, and flags parity and framing errors on every frame.
//            TX and RX share one oversampling tick generator.
// Ports    : clk, rst_n (async, active-low)
//            tx_data/tx_valid/tx_ready - transmit handshake
//            tx                        - serial out, idle high
//            rx                        - serial in, asynchronous to clk
//            rx_data/rx_valid          - received payload, one-cycle strobe
//            rx_parity_err/rx_frame_err- error flags, valid with rx_valid
//            rx_busy                   - receiver inside a frame
// Options  : `define UART_RX_MAJORITY_EN to take each RX sample as the
//            majority of three consecutive ticks around mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int c_DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_TX_W   = $clog2(2 * OVERSAMPLE);
    localparam int c_RX_W   = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam logic [c_TX_W-1:0]  c_BIT_LAST  = c_TX_W'(OVERSAMPLE - 1);
    localparam logic [c_TX_W-1:0]  c_STOP_LAST = c_TX_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [c_RX_W-1:0]  c_RX_LAST   = c_RX_W'(OVERSAMPLE - 1);
    localparam logic [c_RX_W-1:0]  c_RX_MID    = c_RX_W'(OVERSAMPLE / 2);
    localparam logic [c_RX_W-1:0]  c_RX_PRE1   = c_RX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Shared oversampling tick generator
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_b_tick;

    assign w_b_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_div_cnt <= '0;
        else if (w_b_tick) r_div_cnt <= '0;
        else               r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t            r_tx_state;
    logic [c_TX_W-1:0]    r_tx_tick;
    logic [c_BIT_W-1:0]   r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 w_tx_par;

    assign w_tx_par = (PARITY == 2) ? ~(^tx_data) : (^tx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_tx_shift <= tx_data;
                        r_tx_par   <= w_tx_par;
                        tx_ready   <= 1'b0;
                        r_tx_state <= TX_WAIT;
                    end
                end
                // The start edge is launched on a tick so that every bit
                // lasts exactly OVERSAMPLE ticks.
                TX_WAIT: begin
                    if (w_b_tick) begin
                        tx         <= 1'b0;
                        r_tx_tick  <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_b_tick) begin
                        if (r_tx_tick == c_BIT_LAST) begin
                            r_tx_tick  <= '0;
                            r_tx_bit   <= '0;
                            tx         <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (w_b_tick) begin
                        if (r_tx_tick == c_BIT_LAST) begin
                            r_tx_tick <= '0;
                            if (r_tx_bit == c_DATA_LAST) begin
                                if (PARITY != 0) begin
                                    tx         <= r_tx_par;
                                    r_tx_state <= TX_PARITY;
                                end else begin
                                    tx         <= 1'b1;
                                    r_tx_state <= TX_STOP;
                                end
                            end else begin
                                tx         <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                                r_tx_bit   <= r_tx_bit + 1'b1;
                            end
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_b_tick) begin
                        if (r_tx_tick == c_BIT_LAST) begin
                            r_tx_tick  <= '0;
                            tx         <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_b_tick) begin
                        if (r_tx_tick == c_STOP_LAST) begin
                            r_tx_tick  <= '0;
                            tx_ready   <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                default: begin
                    tx         <= 1'b1;
                    tx_ready   <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver front end: 2-FF synchroniser and mid-bit sample capture
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_s1;
    logic w_bit;
    logic [c_RX_W-1:0] r_rx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Sample at tick MID-1 is held and consumed at tick MID, so both
    // builds act on the same tick and have identical latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_s1 <= 1'b1;
        else if (w_b_tick && r_rx_tick == c_RX_PRE1) r_s1 <= r_rx_sync;
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_RX_W-1:0] c_RX_PRE2 = c_RX_W'(OVERSAMPLE / 2 - 2);
    logic r_s0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_s0 <= 1'b1;
        else if (w_b_tick && r_rx_tick == c_RX_PRE2) r_s0 <= r_rx_sync;
    end

    assign w_bit = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
`else
    assign w_bit = r_s1;
`endif

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t            r_rx_state;
    logic [c_BIT_W-1:0]   r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_perr;
    logic                 w_sample;
    logic                 w_rx_par;
    logic [c_RX_W-1:0]    w_rx_tick_nxt;

    assign w_sample      = w_b_tick && (r_rx_tick == c_RX_MID);
    assign w_rx_par      = (PARITY == 2) ? ~(^r_rx_shift) : (^r_rx_shift);
    assign w_rx_tick_nxt = (r_rx_tick == c_RX_LAST) ? '0 : r_rx_tick + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state    <= RX_IDLE;
            r_rx_tick     <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_perr        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Tick phase runs modulo OVERSAMPLE across the whole frame.
            if (w_b_tick && r_rx_state != RX_IDLE) r_rx_tick <= w_rx_tick_nxt;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_tick  <= '0;
                        rx_busy    <= 1'b1;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_sample) begin
                        if (w_bit) begin
                            rx_busy    <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_bit   <= '0;
                            r_perr     <= 1'b0;
                            r_rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_sample) begin
                        r_rx_shift <= {w_bit, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_DATA_LAST) begin
                            r_rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_sample) begin
                        r_perr     <= (w_bit != w_rx_par);
                        r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_sample) begin
                        rx_valid      <= 1'b1;
                        rx_data       <= r_rx_shift;
                        rx_parity_err <= r_perr;
                        rx_frame_err  <= ~w_bit;
                        rx_busy       <= 1'b0;
                        r_rx_state    <= RX_IDLE;
                    end
                end
                default: begin
                    rx_busy    <= 1'b0;
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_core_param
// Purpose  : Self-checking bench for uart_core_param. Three instances:
//            8N1 transmitter, 7E2 tx->rx loopback, 8O1 receiver driven
//            by the bench. Expected line bits come from a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;

    localparam int c_CLK_FREQ = 1_600_000;
    localparam int c_BAUD     = 10_000;
    localparam int c_OS       = 16;
    localparam int c_BITCLK   = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: 8N1
    logic [7:0] a_tx_data;
    logic       a_tx_valid, a_tx_ready, a_tx, a_rx;
    logic [7:0] a_rx_data;
    logic       a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy;
    // Instance B: 7E2 loopback
    logic [6:0] b_tx_data;
    logic       b_tx_valid, b_tx_ready, b_tx;
    logic [6:0] b_rx_data;
    logic       b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_busy;
    // Instance C: 8O1 receiver
    logic [7:0] c_tx_data;
    logic       c_tx_valid, c_tx_ready, c_tx, c_rx;
    logic [7:0] c_rx_data;
    logic       c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_busy;

    uart_core_param #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .OVERSAMPLE(c_OS),
                      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_parity_err(a_rx_perr),
        .rx_frame_err(a_rx_ferr), .rx_busy(a_rx_busy));

    uart_core_param #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .OVERSAMPLE(c_OS),
                      .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .tx(b_tx), .rx(b_tx), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_parity_err(b_rx_perr),
        .rx_frame_err(b_rx_ferr), .rx_busy(b_rx_busy));

    uart_core_param #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .OVERSAMPLE(c_OS),
                      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(c_tx_data), .tx_valid(c_tx_valid),
        .tx_ready(c_tx_ready), .tx(c_tx), .rx(c_rx), .rx_data(c_rx_data),
        .rx_valid(c_rx_valid), .rx_parity_err(c_rx_perr),
        .rx_frame_err(c_rx_ferr), .rx_busy(c_rx_busy));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line-level frame model: bit k of the result is the k-th bit on the wire.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int nb,
                                               input int par, input int stops,
                                               input bit bad_par, input bit stop_val);
        logic [15:0] f;
        int k, ones;
        f = '1;
        f[0] = 1'b0;
        k = 1;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            f[k] = d[i];
            ones += int'(d[i]);
            k++;
        end
        if (par != 0) begin
            f[k] = ((par == 1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ bad_par;
            k++;
        end
        for (int s = 0; s < stops; s++) begin
            f[k] = (s == 0) ? stop_val : 1'b1;
            k++;
        end
        return f;
    endfunction

    // Send one byte on A and capture the line at mid-bit.
    task automatic send_a(input logic [7:0] d, input bit check_width);
        int cyc, t0, idx, last, mn, mx;
        bit seen;
        logic prev;
        logic [15:0] got;
        for (int i = 0; i < 3000 && !a_tx_ready; i++) @(negedge clk);
        check("a_ready_idle", 32'(a_tx_ready), 32'd1);
        @(negedge clk);
        a_tx_data  = d;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_tx_data  = ~d;
        check("a_ready_drop", 32'(a_tx_ready), 32'd0);
        cyc = 0; t0 = 0; idx = 0; last = 0; mn = 99999; mx = 0;
        seen = 0; got = '1; prev = a_tx;
        while (cyc < 2000 && !a_tx_ready) begin
            @(negedge clk);
            cyc++;
            if (!seen && a_tx == 1'b0) begin
                seen = 1; t0 = cyc; last = cyc;
            end else if (seen && a_tx != prev) begin
                if (cyc - last < mn) mn = cyc - last;
                if (cyc - last > mx) mx = cyc - last;
                last = cyc;
            end
            if (seen && idx < 10 && (cyc - t0) % c_BITCLK == c_BITCLK / 2) begin
                got[idx] = a_tx;
                idx++;
            end
            prev = a_tx;
            // a request while busy must be ignored
            if (cyc == 300) begin a_tx_data = 8'h00; a_tx_valid = 1'b1; end
            if (cyc == 301) a_tx_valid = 1'b0;
        end
        check("a_ready_low_cycles", 32'(cyc >= 1601 && cyc <= 1610), 32'd1);
        check("a_tx_bits", 32'(got), 32'(frame_bits(d, 8, 0, 1, 0, 1)));
        check("a_tx_idle", 32'(a_tx), 32'd1);
        if (check_width) check("a_bit_width", {mn[15:0], mx[15:0]}, {16'd160, 16'd160});
    endtask

    // Loopback frame on B.
    task automatic send_b(input logic [6:0] d);
        int cyc, nv;
        logic [6:0] rd;
        logic [1:0] er;
        for (int i = 0; i < 3000 && !b_tx_ready; i++) @(negedge clk);
        @(negedge clk);
        b_tx_data  = d;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        cyc = 0; nv = 0; rd = '0; er = 2'b11;
        while (cyc < 2500 && !b_tx_ready) begin
            @(negedge clk);
            cyc++;
            if (b_rx_valid) begin nv++; rd = b_rx_data; er = {b_rx_perr, b_rx_ferr}; end
        end
        check("b_ready_low_cycles", 32'(cyc >= 1761 && cyc <= 1770), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_rx_valid) nv++;
        end
        check("b_rx_count", 32'(nv), 32'd1);
        check("b_rx_data", 32'(rd), 32'(d));
        check("b_rx_errs", 32'(er), 32'd0);
    endtask

    // Drive one 8O1 frame into C; glitch_bit>=0 inserts a 10-clk low pulse.
    task automatic drive_c(input logic [7:0] d, input bit bad_par, input bit stop_val,
                           input int glitch_bit);
        logic [15:0] f;
        int nv;
        logic [7:0] rd;
        logic pe, fe;
        f = frame_bits(d, 8, 2, 1, bad_par, stop_val);
        nv = 0; rd = '0; pe = 1'b0; fe = 1'b0;
        for (int g = $urandom_range(0, 25); g > 0; g--) @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < c_BITCLK; k++) begin
                c_rx = f[b];
                if (b == glitch_bit && k >= 75 && k < 85) c_rx = 1'b0;
                @(negedge clk);
                if (c_rx_valid) begin nv++; rd = c_rx_data; pe = c_rx_perr; fe = c_rx_ferr; end
            end
        end
        c_rx = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (c_rx_valid) nv++;
        end
        check("c_rx_count", 32'(nv), 32'd1);
        check("c_rx_data", 32'(rd), 32'(d));
        check("c_rx_perr", 32'(pe), 32'(bad_par));
        check("c_rx_ferr", 32'(fe), 32'(!stop_val));
        check("c_busy_end", 32'(c_rx_busy), 32'd0);
    endtask

    task automatic false_start_c();
        int nv, t;
        bit busy_seen;
        nv = 0; busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            c_rx = 1'b0;
            @(negedge clk);
            if (c_rx_busy) busy_seen = 1;
        end
        c_rx = 1'b1;
        t = 0;
        while (c_rx_busy && t < 200) begin
            @(negedge clk);
            t++;
            if (c_rx_valid) nv++;
        end
        check("c_false_busy_seen", 32'(busy_seen), 32'd1);
        check("c_false_busy_clear", 32'(t <= 90), 32'd1);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (c_rx_valid) nv++;
        end
        check("c_false_no_valid", 32'(nv), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst_n = 1'b0;
        a_tx_data = '0; a_tx_valid = 1'b0; a_rx = 1'b1;
        b_tx_data = '0; b_tx_valid = 1'b0;
        c_tx_data = '0; c_tx_valid = 1'b0; c_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("a_reset_flags", {26'd0, a_tx, a_tx_ready, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy},
              32'b110000);
        check("a_reset_rxdata", 32'(a_rx_data), 32'd0);
        check("c_reset_flags", {26'd0, c_tx, c_tx_ready, c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_busy},
              32'b110000);
        check("b_reset_flags", {26'd0, b_tx, b_tx_ready, b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_busy},
              32'b110000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 transmit
        send_a(8'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            send_a(d, 1'b0);
        end

        // 7E2 loopback
        send_b(7'h41);
        for (int i = 0; i < 2; i++) send_b(7'($urandom));

        // 8O1 receive
        drive_c(8'hA5, 1'b1, 1'b1, -1);
        drive_c(8'h3C, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            drive_c(d, 1'($urandom), 1'b1, -1);
        end
        false_start_c();
`ifdef UART_RX_MAJORITY_EN
        drive_c(8'hFF, 1'b0, 1'b1, 4);
`endif

        // Reset in the middle of a transmit
        @(negedge clk);
        a_tx_data  = 8'h81;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (500) @(negedge clk);
        check("a_midframe_busy", 32'(a_tx_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_async_reset_tx", {30'd0, a_tx, a_tx_ready}, 32'b11);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_a(8'h81, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
